// File: rtl/dds_wr_if.sv
// Register write port of the multichannel DDS core.
//   wr_valid / wr_ready : handshake, a write is accepted when both are high
//   wr_ch               : target channel
//   wr_addr             : 0 step, 1 phase, 2 duty, 3 mode, 4 sweep_delta, 5 sweep_stop
//   wr_data             : write data (mode: [1:0] wave, [2] sweep_en)
//   wr_err              : one-cycle pulse after an accepted write to a bad channel/address
interface dds_wr_if #(
  parameter int ACC_W = 32
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_ch;
  logic [2:0]       wr_addr;
  logic [ACC_W-1:0] wr_data;
  logic             wr_err;

  modport master (
    output wr_valid, wr_ch, wr_addr, wr_data,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_ch, wr_addr, wr_data,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/dds_multichannel_core.sv
// N-channel phase-accumulator DDS engine.
// Each channel owns a frequency step, phase offset, PWM duty, waveform mode
// and an optional linear frequency sweep. Settings land in shadow registers
// through the write port and are committed to all channels at once by apply_i.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   run_i      1 = accumulators advance, 0 = accumulators and samples hold
//   sync_i     pulse: zero every accumulator
//   apply_i    pulse: copy all shadow registers into the active set
//   wr         register write port (slave side of dds_wr_if)
//   sig_out_o  channel k sample at [k*OUT_W +: OUT_W]
//   wrap_o     per-channel one-cycle pulse on accumulator carry
module dds_multichannel_core #(
  parameter int CH    = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                run_i,
  input  logic                sync_i,
  input  logic                apply_i,
  dds_wr_if.slave             wr,
  output logic [CH*OUT_W-1:0] sig_out_o,
  output logic [CH-1:0]       wrap_o
);

  typedef struct packed {
    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] phase;
    logic [ACC_W-1:0] duty;
    logic [1:0]       wave;
    logic             swen;
    logic [ACC_W-1:0] delta;
    logic [ACC_W-1:0] stop;
  } cfg_t;

  localparam logic [ACC_W-1:0] DUTY_RST = {1'b1, {(ACC_W-1){1'b0}}};
  localparam cfg_t CFG_RST = '{
    step:  '0,
    phase: '0,
    duty:  DUTY_RST,
    wave:  2'd0,
    swen:  1'b0,
    delta: '0,
    stop:  '1
  };

  // Sample shaping from the offset phase p.
  function automatic logic [OUT_W-1:0] wave_fn(
    input logic [ACC_W-1:0] p,
    input logic [ACC_W-1:0] duty,
    input logic [1:0]       wave
  );
    logic [OUT_W-1:0] r;
    r = p[ACC_W-2 -: OUT_W];
    case (wave)
      2'd0:    wave_fn = p[ACC_W-1 -: OUT_W];
      2'd1:    wave_fn = p[ACC_W-1] ? ~r : r;
      2'd2:    wave_fn = (p < duty) ? '1 : '0;
      default: wave_fn = p[ACC_W-1] ? '0 : '1;
    endcase
  endfunction

  // Next sweep step: grow by delta, fall back to the start step past stop.
  function automatic logic [ACC_W-1:0] sweep_fn(
    input logic [ACC_W-1:0] cur,
    input logic [ACC_W-1:0] delta,
    input logic [ACC_W-1:0] stop,
    input logic [ACC_W-1:0] start
  );
    logic [ACC_W:0] n;
    n = {1'b0, cur} + {1'b0, delta};
    sweep_fn = (n > {1'b0, stop}) ? start : n[ACC_W-1:0];
  endfunction

  cfg_t             shd_q [CH];
  cfg_t             shd_d [CH];
  cfg_t             act_q [CH];
  cfg_t             act_d [CH];
  logic [ACC_W-1:0] acc_q [CH];
  logic [ACC_W-1:0] acc_d [CH];
  logic [ACC_W-1:0] cur_q [CH];
  logic [ACC_W-1:0] cur_d [CH];
  logic [OUT_W-1:0] sig_q [CH];
  logic [OUT_W-1:0] sig_d [CH];
  logic [CH-1:0]    wrap_q;
  logic [CH-1:0]    wrap_d;
  logic             err_q;
  logic             err_d;

  logic [ACC_W:0]   sum_w [CH];
  logic [ACC_W-1:0] ph_w  [CH];
  logic             wr_accept;
  logic             wr_ok;

  // Writes stall during reset and during the apply cycle so a commit never
  // races a shadow update.
  assign wr.wr_ready = ~reset_i & ~apply_i;
  assign wr.wr_err   = err_q;

  assign wr_accept = wr.wr_valid & wr.wr_ready;
  assign wr_ok     = (5'(wr.wr_ch) < 5'(CH)) && (wr.wr_addr <= 3'd5);

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      sum_w[k] = {1'b0, acc_q[k]} + {1'b0, cur_q[k]};
      ph_w[k]  = acc_q[k] + act_q[k].phase;
    end
  end

  always_comb begin
    shd_d  = shd_q;
    act_d  = act_q;
    acc_d  = acc_q;
    cur_d  = cur_q;
    sig_d  = sig_q;
    wrap_d = '0;
    err_d  = wr_accept & ~wr_ok;

    // Shadow register file.
    for (int k = 0; k < CH; k++) begin
      if (wr_accept && wr_ok && (wr.wr_ch == 4'(k))) begin
        case (wr.wr_addr)
          3'd0: shd_d[k].step  = wr.wr_data;
          3'd1: shd_d[k].phase = wr.wr_data;
          3'd2: shd_d[k].duty  = wr.wr_data;
          3'd3: begin
            shd_d[k].wave = wr.wr_data[1:0];
            shd_d[k].swen = wr.wr_data[2];
          end
          3'd4: shd_d[k].delta = wr.wr_data;
          3'd5: shd_d[k].stop  = wr.wr_data;
          default: ;
        endcase
      end
    end

    // Per-channel datapath. Priority low to high: run, apply, sync.
    for (int k = 0; k < CH; k++) begin
      if (run_i) begin
        acc_d[k]  = sum_w[k][ACC_W-1:0];
        wrap_d[k] = sum_w[k][ACC_W];
        sig_d[k]  = wave_fn(ph_w[k], act_q[k].duty, act_q[k].wave);
        if (act_q[k].swen && sum_w[k][ACC_W])
          cur_d[k] = sweep_fn(cur_q[k], act_q[k].delta, act_q[k].stop, act_q[k].step);
      end
      // The active step doubles as the sweep start, so the reload here wins
      // over a sweep update in the same cycle.
      if (apply_i) begin
        act_d[k] = shd_q[k];
        cur_d[k] = shd_q[k].step;
      end
      if (sync_i) begin
        acc_d[k]  = '0;
        wrap_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < CH; k++) begin
        shd_q[k] <= CFG_RST;
        act_q[k] <= CFG_RST;
        acc_q[k] <= '0;
        cur_q[k] <= '0;
        sig_q[k] <= '0;
      end
      wrap_q <= '0;
      err_q  <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      act_q  <= act_d;
      acc_q  <= acc_d;
      cur_q  <= cur_d;
      sig_q  <= sig_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    sig_out_o = '0;
    for (int k = 0; k < CH; k++)
      sig_out_o[k*OUT_W +: OUT_W] = sig_q[k];
  end

  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_dds_multichannel_core.sv
module tb_dds_multichannel_core;
  localparam int CH    = 2;
  localparam int ACC_W = 8;
  localparam int OUT_W = 4;

  logic clk = 1'b0;
  logic reset, run, sync, apply;
  logic [CH*OUT_W-1:0] sig_out;
  logic [CH-1:0]       wrap;

  dds_wr_if #(.ACC_W(ACC_W)) wrb ();

  dds_multichannel_core #(.CH(CH), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .run_i     (run),
    .sync_i    (sync),
    .apply_i   (apply),
    .wr        (wrb),
    .sig_out_o (sig_out),
    .wrap_o    (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int s_step[CH], s_ph[CH], s_duty[CH], s_wave[CH], s_swen[CH], s_dl[CH], s_stop[CH];
  int a_step[CH], a_ph[CH], a_duty[CH], a_wave[CH], a_swen[CH], a_dl[CH], a_stop[CH];
  int m_acc[CH], m_cur[CH], m_sig[CH];
  int m_wrap, m_err;

  typedef struct {
    int sig0;
    int sig1;
    int wr;
    int err;
  } exp_t;
  exp_t sb[$];

  function automatic int wave_model(int p, int duty, int wv);
    int r;
    r = (p >> 3) & 15;
    case (wv)
      0:       return (p >> 4) & 15;
      1:       return (p >= 128) ? 15 - r : r;
      2:       return (p < duty) ? 15 : 0;
      default: return (p >= 128) ? 0 : 15;
    endcase
  endfunction

  task automatic model_edge();
    int p, s, n, nacc, ncur, ch, ad, dt;
    bit nw, wacc, ok;
    exp_t e;
    if (reset) begin
      for (int k = 0; k < CH; k++) begin
        s_step[k] = 0; s_ph[k] = 0; s_duty[k] = 128; s_wave[k] = 0;
        s_swen[k] = 0; s_dl[k] = 0; s_stop[k] = 255;
        a_step[k] = 0; a_ph[k] = 0; a_duty[k] = 128; a_wave[k] = 0;
        a_swen[k] = 0; a_dl[k] = 0; a_stop[k] = 255;
        m_acc[k] = 0; m_cur[k] = 0; m_sig[k] = 0;
      end
      m_wrap = 0;
      m_err  = 0;
    end else begin
      ch   = int'(wrb.wr_ch);
      ad   = int'(wrb.wr_addr);
      dt   = int'(wrb.wr_data);
      wacc = wrb.wr_valid && !apply;
      ok   = (ch < CH) && (ad <= 5);
      m_wrap = 0;
      for (int k = 0; k < CH; k++) begin
        p    = (m_acc[k] + a_ph[k]) & 255;
        s    = m_acc[k] + m_cur[k];
        nacc = m_acc[k];
        ncur = m_cur[k];
        nw   = 0;
        if (run) begin
          m_sig[k] = wave_model(p, a_duty[k], a_wave[k]);
          nacc = s & 255;
          nw   = (s > 255);
          if (a_swen[k] != 0 && s > 255) begin
            n    = m_cur[k] + a_dl[k];
            ncur = (n > a_stop[k]) ? a_step[k] : n;
          end
        end
        if (apply) begin
          a_step[k] = s_step[k]; a_ph[k] = s_ph[k]; a_duty[k] = s_duty[k];
          a_wave[k] = s_wave[k]; a_swen[k] = s_swen[k]; a_dl[k] = s_dl[k];
          a_stop[k] = s_stop[k];
          ncur = s_step[k];
        end
        if (sync) begin
          nacc = 0;
          nw   = 0;
        end
        m_acc[k] = nacc;
        m_cur[k] = ncur;
        if (nw) m_wrap = m_wrap | (1 << k);
      end
      m_err = (wacc && !ok) ? 1 : 0;
      if (wacc && ok) begin
        case (ad)
          0: s_step[ch] = dt;
          1: s_ph[ch]   = dt;
          2: s_duty[ch] = dt;
          3: begin s_wave[ch] = dt & 3; s_swen[ch] = (dt >> 2) & 1; end
          4: s_dl[ch]   = dt;
          default: s_stop[ch] = dt;
        endcase
      end
    end
    e.sig0 = m_sig[0];
    e.sig1 = m_sig[1];
    e.wr   = m_wrap;
    e.err  = m_err;
    sb.push_back(e);
  endtask

  // Scoreboard: compare each DUT edge against the entry queued for it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_sig0", int'(sig_out[3:0]), e.sig0);
      chk("sb_sig1", int'(sig_out[7:4]), e.sig1);
      chk("sb_wrap", int'(wrap), e.wr);
      chk("sb_err", int'(wrb.wr_err), e.err);
    end
  end

  // One clock: inputs were set at the previous negedge; returns at the next negedge.
  task automatic tick();
    #1;
    if (wrb.wr_valid)
      chk("wr_ready", int'(wrb.wr_ready), (!reset && !apply) ? 1 : 0);
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int ch, input int ad, input int dt);
    wrb.wr_valid = 1'b1;
    wrb.wr_ch    = 4'(ch);
    wrb.wr_addr  = 3'(ad);
    wrb.wr_data  = 8'(dt);
    tick();
    wrb.wr_valid = 1'b0;
  endtask

  task automatic apply_sync();
    apply = 1'b1;
    sync  = 1'b1;
    tick();
    apply = 1'b0;
    sync  = 1'b0;
  endtask

  initial begin
    int idx;
    reset = 1'b1; run = 1'b0; sync = 1'b0; apply = 1'b0;
    wrb.wr_valid = 1'b0; wrb.wr_ch = '0; wrb.wr_addr = '0; wrb.wr_data = '0;
    tick();
    tick();
    chk("rst_sig", int'(sig_out), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_err", int'(wrb.wr_err), 0);
    reset = 1'b0;

    // Saw on ch0, ch1 idle.
    wr(0, 0, 8'h10);
    apply = 1'b1; tick(); apply = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("saw_ch0", int'(sig_out[3:0]), (k - 1) & 15);
      chk("saw_ch1", int'(sig_out[7:4]), 0);
      chk("saw_wrap", int'(wrap[0]), (k % 16 == 0) ? 1 : 0);
    end

    // Triangle, then with half-cycle phase offset.
    wr(0, 3, 1);
    wr(0, 0, 8'h08);
    apply_sync();
    for (int k = 1; k <= 34; k++) begin
      tick();
      idx = (k - 1) % 32;
      chk("tri_ch0", int'(sig_out[3:0]), (idx < 16) ? idx : 31 - idx);
    end
    wr(0, 1, 8'h80);
    apply_sync();
    for (int k = 1; k <= 18; k++) begin
      tick();
      idx = (k - 1 + 16) % 32;
      chk("tri_ph_ch0", int'(sig_out[3:0]), (idx < 16) ? idx : 31 - idx);
    end

    // PWM / square on ch1.
    wr(1, 3, 2);
    wr(1, 2, 8'h40);
    wr(1, 0, 8'h40);
    apply_sync();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("pwm_ch1", int'(sig_out[7:4]), ((k - 1) % 4 == 0) ? 15 : 0);
    end
    wr(1, 2, 0);
    apply_sync();
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("pwm0_ch1", int'(sig_out[7:4]), 0);
    end
    wr(1, 3, 3);
    apply_sync();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("sq_ch1", int'(sig_out[7:4]), ((k - 1) % 4 < 2) ? 15 : 0);
    end

    // Linear sweep on ch0.
    wr(0, 0, 8'h40);
    wr(0, 4, 8'h40);
    wr(0, 5, 8'h80);
    wr(0, 3, 4);
    wr(0, 1, 0);
    apply_sync();
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk("swp_wrap", int'(wrap[0]), (k % 6 == 4 || k % 6 == 0) ? 1 : 0);
    end
    // Apply landing on a carry edge reloads the start step.
    apply_sync();
    for (int k = 1; k <= 3; k++) tick();
    apply = 1'b1; tick(); apply = 1'b0;
    chk("swp_apply_carry", int'(wrap[0]), 1);
    for (int k = 5; k <= 8; k++) begin
      tick();
      chk("swp_apply_wrap", int'(wrap[0]), (k == 8) ? 1 : 0);
    end

    // Write port corner cases.
    apply = 1'b1;
    wrb.wr_valid = 1'b1; wrb.wr_ch = 4'd1; wrb.wr_addr = 3'd0; wrb.wr_data = 8'h20;
    tick();
    wrb.wr_valid = 1'b0;
    apply = 1'b0;
    apply = 1'b1; tick(); apply = 1'b0;
    wr(2, 0, 8'h55);
    chk("err_pulse", int'(wrb.wr_err), 1);
    tick();
    chk("err_clear", int'(wrb.wr_err), 0);
    wr(0, 6, 8'h11);
    chk("err_addr", int'(wrb.wr_err), 1);
    wr(0, 0, 8'h80);
    for (int k = 0; k < 6; k++) tick();

    // Sync, hold, reset mid-sweep.
    sync = 1'b1; tick(); sync = 1'b0;
    chk("sync_wrap", int'(wrap), 0);
    tick();
    chk("sync_ch0", int'(sig_out[3:0]), 0);
    chk("sync_ch1", int'(sig_out[7:4]), 15);
    for (int k = 0; k < 5; k++) tick();
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_wrap", int'(wrap), 0);
    end
    run = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_sig", int'(sig_out), 0);
    chk("rst2_wrap", int'(wrap), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst2_run_sig", int'(sig_out), 0);
    end

    // Randomised traffic, checked by the scoreboard.
    for (int k = 0; k < 400; k++) begin
      run   = ($urandom_range(0, 9) != 0);
      sync  = ($urandom_range(0, 29) == 0);
      apply = ($urandom_range(0, 7) == 0);
      wrb.wr_valid = ($urandom_range(0, 1) == 1);
      wrb.wr_ch    = 4'($urandom_range(0, 2));
      wrb.wr_addr  = 3'($urandom_range(0, 6));
      wrb.wr_data  = 8'($urandom_range(0, 255));
      tick();
    end
    run = 1'b0; sync = 1'b0; apply = 1'b0; wrb.wr_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
